// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding and the
// watchdog base margin (nominal WAIT length beyond the launched count).
package timer_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT
  } state_t;

  // A healthy timer answers in the (count+2)th WAIT cycle.
  localparam int WD_BASE = 2;

endpackage

// File: rtl/timer_sequencer_if.sv
// Link between the sequencer (master) and the single-shot timer (slave).
// Handshake: timer_start is a one-cycle strobe and timer_count is valid only
// while it is high; timer_rst is a one-cycle synchronous reset strobe;
// timer_done is a one-cycle strobe back from the timer. There is no
// backpressure in either direction.
interface timer_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             timer_start;
  logic [WIDTH-1:0] timer_count;
  logic             timer_rst;
  logic             timer_done;

  modport master (
    output timer_start,
    output timer_count,
    output timer_rst,
    input  timer_done
  );

  modport slave (
    input  timer_start,
    input  timer_count,
    input  timer_rst,
    output timer_done
  );
endinterface

// File: rtl/timer_seq_table.sv
// Interval table: DEPTH x WIDTH register file, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module timer_seq_table #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store a new interval; visible to reads from the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: plays the interval table back to a single-shot timer,
// one start pulse per entry, advancing on each timer done pulse.
// Optional feature: define SEQ_WATCHDOG_EN to add a per-entry watchdog
// that aborts the sequence and pulses wd_err when the timer never answers.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH)
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter int WD_SLACK = 4
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             go,
  input  logic             abort,
  timer_sequencer_if.master tmr,
  output logic             busy,
  output logic [AW-1:0]    phase,
  output logic             seq_done,
`ifdef SEQ_WATCHDOG_EN
  output logic             wd_err,
`endif
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  logic             r_busy;
  logic [AW-1:0]    r_phase;
  logic [AW:0]      r_eff_len;
  logic             r_timer_start;
  logic [WIDTH-1:0] r_timer_count;
  logic             r_timer_rst;
  logic             r_seq_done;

  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic [AW-1:0]    w_phase_nxt;
  logic [AW:0]      w_eff_len_nxt;
  logic             w_start_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_rst_nxt;
  logic             w_seq_done_nxt;
  logic             w_wd_err_nxt;

  logic [AW-1:0]    w_phase_inc;
  logic             w_is_last;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_wd_hit;

  assign w_phase_inc = r_phase + AW'(1);
  // Last entry when phase+1 reaches the latched length (no reliance on wrap).
  assign w_is_last   = ((AW+1)'(r_phase) + (AW+1)'(1)) >= r_eff_len;
  // Read address is the entry that would load on the next launch.
  assign w_rd_addr   = (r_state == S_WAIT && !w_is_last) ? w_phase_inc : '0;

  timer_seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .i_clk     (clk_i),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

`ifdef SEQ_WATCHDOG_EN
  logic [WIDTH:0]   r_wd_cnt;
  logic             r_wd_err;
  logic [WIDTH+1:0] w_wd_cnt_inc;
  logic [WIDTH+1:0] w_wd_limit;

  assign w_wd_cnt_inc = (WIDTH+2)'(r_wd_cnt) + (WIDTH+2)'(1);
  assign w_wd_limit   = (WIDTH+2)'(r_timer_count) + (WIDTH+2)'(WD_BASE + WD_SLACK);
  // Fires on the WAIT cycle that would bring the count to the limit.
  assign w_wd_hit     = (r_state == S_WAIT) && (w_wd_cnt_inc == w_wd_limit);

  // Count WAIT cycles of the current entry; cleared as WAIT is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
      r_wd_err <= 1'b0;
    end else begin
      r_wd_err <= w_wd_err_nxt;
      if (r_state == S_LAUNCH) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd_cnt <= w_wd_cnt_inc[WIDTH:0];
      end
    end
  end

  assign wd_err = r_wd_err;
`else
  assign w_wd_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = r_busy;
    w_phase_nxt    = r_phase;
    w_eff_len_nxt  = r_eff_len;
    w_start_nxt    = 1'b0;
    w_count_nxt    = r_timer_count;
    w_rst_nxt      = 1'b0;
    w_seq_done_nxt = 1'b0;
    w_wd_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go && (len != '0)) begin
          w_state_nxt   = S_LAUNCH;
          w_eff_len_nxt = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
          w_phase_nxt   = '0;
          w_count_nxt   = w_rd_data;
          w_start_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_rst_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_rst_nxt   = 1'b1;
        end else if (tmr.timer_done) begin
          if (!w_is_last) begin
            w_state_nxt = S_LAUNCH;
            w_phase_nxt = w_phase_inc;
            w_count_nxt = w_rd_data;
            w_start_nxt = 1'b1;
          end else if (loop) begin
            w_state_nxt = S_LAUNCH;
            w_phase_nxt = '0;
            w_count_nxt = w_rd_data;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_IDLE;
            w_busy_nxt     = 1'b0;
            w_seq_done_nxt = 1'b1;
          end
        end else if (w_wd_hit) begin
          w_state_nxt  = S_IDLE;
          w_busy_nxt   = 1'b0;
          w_rst_nxt    = 1'b1;
          w_wd_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs and sequence bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy        <= 1'b0;
      r_phase       <= '0;
      r_eff_len     <= '0;
      r_timer_start <= 1'b0;
      r_timer_count <= '0;
      r_timer_rst   <= 1'b0;
      r_seq_done    <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_phase       <= w_phase_nxt;
      r_eff_len     <= w_eff_len_nxt;
      r_timer_start <= w_start_nxt;
      r_timer_count <= w_count_nxt;
      r_timer_rst   <= w_rst_nxt;
      r_seq_done    <= w_seq_done_nxt;
    end
  end

  assign tmr.timer_start = r_timer_start;
  assign tmr.timer_count = r_timer_count;
  assign tmr.timer_rst   = r_timer_rst;
  assign busy            = r_busy;
  assign phase           = r_phase;
  assign seq_done        = r_seq_done;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer with a behavioural single-shot timer attached.
// Build with SEQ_WATCHDOG_EN defined to also exercise the watchdog.
module tb_timer_sequencer;
  import timer_seq_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int WD_SLACK = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [AW:0]      len = '0;
  logic             loop = 1'b0;
  logic             go = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic [AW-1:0]    phase;
  logic             seq_done;
  logic [1:0]       dbg_state;
`ifdef SEQ_WATCHDOG_EN
  logic             wd_err;
`endif

  timer_sequencer_if #(.WIDTH(WIDTH)) tif ();

  timer_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef SEQ_WATCHDOG_EN
    ,
    .WD_SLACK (WD_SLACK)
`endif
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .loop      (loop),
    .go        (go),
    .abort     (abort),
    .tmr       (tif),
    .busy      (busy),
    .phase     (phase),
    .seq_done  (seq_done),
`ifdef SEQ_WATCHDOG_EN
    .wd_err    (wd_err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- timer model ----------------
  // Samples start one edge after it is driven; done is seen by the sequencer
  // count+3 edges after the start edge.
  logic tm_armed = 1'b0;
  logic tm_mute  = 1'b0;
  int   tm_left  = 0;
  always @(negedge clk) begin
    tif.timer_done = 1'b0;
    if (tif.timer_rst) begin
      tm_armed = 1'b0;
    end else if (tif.timer_start) begin
      tm_armed = 1'b1;
      tm_left  = int'(tif.timer_count) + 1;
    end else if (tm_armed) begin
      if (tm_left == 0) begin
        tif.timer_done = !tm_mute;
        tm_armed       = 1'b0;
      end else begin
        tm_left--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               exp_ph_q[$];
  logic [WIDTH-1:0] shadow [DEPTH];
  int exp_next_cyc = -1;
  int exp_rst_cyc  = -1;
  int exp_wd_cyc   = -1;
  int n_starts = 0, n_seq_done = 0, n_rst = 0, n_wd = 0;
  int exp_n_done = 0, exp_n_rst = 0;
  int last_start_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tif.timer_start) begin
        n_starts++;
        last_start_cyc = cyc;
        check_eq("start_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [WIDTH-1:0] ec;
          int               ep;
          ec = exp_q.pop_front();
          ep = exp_ph_q.pop_front();
          check_eq("start_count", tif.timer_count, ec);
          check_eq("start_phase", phase, ep);
          check_eq("start_busy", busy, 1);
          check_eq("start_cycle", cyc, exp_next_cyc);
          exp_next_cyc = cyc + int'(ec) + 3;
        end
      end
      if (seq_done) begin
        n_seq_done++;
        check_eq("done_cycle", cyc, exp_next_cyc);
        check_eq("done_left", exp_q.size(), 0);
        check_eq("done_busy", busy, 0);
      end
      if (tif.timer_rst) begin
        n_rst++;
        check_eq("rst_cycle", cyc, exp_rst_cyc);
      end
`ifdef SEQ_WATCHDOG_EN
      if (wd_err) begin
        n_wd++;
        check_eq("wd_cycle", cyc, exp_wd_cyc);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(d);
    shadow[a] = WIDTH'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue_go(input int l, input int lp);
    int eff;
    eff = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(shadow[i]);
      exp_ph_q.push_back(i);
    end
    len  = (AW+1)'(l);
    loop = lp[0];
    go   = 1'b1;
    exp_next_cyc = cyc + 1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base, t;
    base = n_seq_done;
    t = 0;
    while (n_seq_done == base && t < budget) begin
      step();
      t++;
    end
    check_eq("seq_done_seen", n_seq_done - base, 1);
    if (n_seq_done != base) exp_n_done++;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t;
    t = 0;
    while (n_starts < target && t < budget) begin
      step();
      t++;
    end
    check_eq("starts_reached", 32'(n_starts >= target), 1);
  endtask

  // ---------------- stimulus ----------------
  int base, s, l, eff;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", tif.timer_start, 0);
    check_eq("rst_trst", tif.timer_rst, 0);
    check_eq("rst_seqdone", seq_done, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_count", tif.timer_count, 0);
    check_eq("rst_state", dbg_state, 0);
`ifdef SEQ_WATCHDOG_EN
    check_eq("rst_wderr", wd_err, 0);
`endif
    rst_n = 1'b1;
    step();

    // Table {3,0,5,1}, len=4: starts spaced 6,3,8 and one seq_done.
    write_entry(0, 3); write_entry(1, 0); write_entry(2, 5); write_entry(3, 1);
    base = n_starts;
    issue_go(4, 0);
    wait_done(200);
    check_eq("t1_starts", n_starts - base, 4);

    // len=0 is ignored.
    base = n_starts;
    issue_go(0, 0);
    repeat (10) step();
    check_eq("len0_starts", n_starts - base, 0);
    check_eq("len0_busy", busy, 0);

    // len=7 clamps to DEPTH entries.
    for (int i = 0; i < DEPTH; i++) write_entry(i, $urandom_range(0, 6));
    base = n_starts;
    issue_go(7, 0);
    wait_done(200);
    check_eq("len7_starts", n_starts - base, DEPTH);

    // Loop with len=2 on {1,2}; drop loop during the third entry-1 pass.
    write_entry(0, 1); write_entry(1, 2);
    base = n_starts;
    issue_go(2, 1);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(shadow[0]); exp_ph_q.push_back(0);
      exp_q.push_back(shadow[1]); exp_ph_q.push_back(1);
    end
    wait_starts(base + 6, 200);
    loop = 1'b0;
    wait_done(100);
    check_eq("loop_starts", n_starts - base, 6);

    // Table write during entry 0 reaches entry 1.
    write_entry(0, 6); write_entry(1, 1);
    write_entry(2, $urandom_range(0, 6)); write_entry(3, $urandom_range(0, 6));
    issue_go(4, 0);
    write_entry(1, 9);
    exp_q[0] = shadow[1];
    wait_done(200);

    // Abort one cycle into WAIT of entry 2, with a simultaneous go.
    for (int i = 0; i < DEPTH; i++) write_entry(i, $urandom_range(2, 6));
    base = n_starts;
    issue_go(4, 0);
    wait_starts(base + 3, 200);
    s = last_start_cyc;
    step();
    check_eq("abort_at_wait", cyc, s + 1);
    abort = 1'b1;
    go    = 1'b1;
    exp_rst_cyc = cyc + 1;
    exp_n_rst++;
    step();
    abort = 1'b0;
    go    = 1'b0;
    exp_q.delete();
    exp_ph_q.delete();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_trst", tif.timer_rst, 1);
    check_eq("abort_seqdone", seq_done, 0);
    check_eq("abort_state", dbg_state, 0);
    step();
    check_eq("abort_trst_off", tif.timer_rst, 0);
    repeat (15) step();
    check_eq("abort_starts", n_starts - base, 3);
    check_eq("abort_busy_late", busy, 0);

    // Abort while idle does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (3) step();
    check_eq("idle_abort_trst", n_rst, exp_n_rst);

    // Random sequences.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) write_entry(i, $urandom_range(0, 7));
      l   = $urandom_range(0, 7);
      eff = (l > DEPTH) ? DEPTH : l;
      base = n_starts;
      issue_go(l, 0);
      if (eff > 0) begin
        wait_done(200);
      end else begin
        repeat (6) step();
      end
      check_eq("rand_starts", n_starts - base, eff);
      check_eq("rand_idle_busy", busy, 0);
    end

`ifdef SEQ_WATCHDOG_EN
    // Timer never answers: watchdog aborts after count+2+WD_SLACK WAIT cycles.
    tm_mute = 1'b1;
    write_entry(0, 2);
    base = n_starts;
    issue_go(1, 0);
    wait_starts(base + 1, 20);
    exp_wd_cyc  = last_start_cyc + 1 + 2 + 2 + WD_SLACK;
    exp_rst_cyc = exp_wd_cyc;
    exp_n_rst++;
    begin
      int t;
      t = 0;
      while (n_wd == 0 && t < 40) begin
        step();
        t++;
      end
    end
    check_eq("wd_seen", n_wd, 1);
    check_eq("wd_busy", busy, 0);
    check_eq("wd_state", dbg_state, 0);
    tm_mute = 1'b0;
    repeat (3) step();
`endif

    check_eq("total_seq_done", n_seq_done, exp_n_done);
    check_eq("total_trst", n_rst, exp_n_rst);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
